// File: rtl/div_result_display.sv
// Display stage for the signed divider: serial binary-to-BCD conversion feeding three
// active-low seven-segment digits that alternate between quotient and remainder.
module div_result_display #(
  parameter int WIDTH         = 6,
  parameter int TOGGLE_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] cociente,
  input  logic [WIDTH-1:0] residuo,
  input  logic             neg,
  output logic             busy,
  output logic             sel_rem,
  output logic [6:0]       HEX_0,
  output logic [6:0]       HEX_1,
  output logic [6:0]       HEX_2
);
  localparam int CW = (TOGGLE_CYCLES > 2) ? $clog2(TOGGLE_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(TOGGLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_r, r_r;
  logic             n_r;
  logic [7:0]       bcd_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [BW-1:0]    cnt_reg;
  logic [CW-1:0]    tick_reg;
  logic             pending_reg, armed_reg, conv_neg_reg;
  logic [7:0]       bcd_adj, bcd_step;
  logic [WIDTH-1:0] bin_step;
  logic             timeout, last_shift;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction per nibble, then shift the next binary MSB into the BCD field.
  for (genvar gi = 0; gi < 2; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
  end
  assign {bcd_step, bin_step} = {bcd_adj, bin_reg} << 1;

  assign timeout    = armed_reg && (tick_reg == LAST);
  assign last_shift = (cnt_reg == BW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_rem      <= 1'b0;
      tick_reg     <= '0;
      pending_reg  <= 1'b0;
      armed_reg    <= 1'b0;
      conv_neg_reg <= 1'b0;
      q_r          <= '0;
      r_r          <= '0;
      n_r          <= 1'b0;
      bcd_reg      <= '0;
      bin_reg      <= '0;
      cnt_reg      <= '0;
      HEX_0        <= SEG_BLANK;
      HEX_1        <= SEG_BLANK;
      HEX_2        <= SEG_BLANK;
    end else begin
      state_reg <= state_next;
      if (valid) begin
        q_r       <= cociente;
        r_r       <= residuo;
        n_r       <= neg;
        armed_reg <= 1'b1;
      end
      // Saturating dwell counter; a timeout reached while busy waits for IDLE.
      if (tick_reg != LAST)
        tick_reg <= tick_reg + CW'(1);
      case (state_reg)
        IDLE: begin
          if (valid || pending_reg) begin
            pending_reg  <= 1'b0;
            sel_rem      <= 1'b0;
            tick_reg     <= '0;
            bin_reg      <= valid ? cociente : q_r;
            conv_neg_reg <= valid ? neg : n_r;
            bcd_reg      <= '0;
            cnt_reg      <= BW'(WIDTH);
          end else if (timeout) begin
            tick_reg     <= '0;
            sel_rem      <= ~sel_rem;
            bin_reg      <= sel_rem ? q_r : r_r;
            conv_neg_reg <= n_r;
            bcd_reg      <= '0;
            cnt_reg      <= BW'(WIDTH);
          end
        end
        CONV: begin
          bcd_reg <= bcd_step;
          bin_reg <= bin_step;
          cnt_reg <= cnt_reg - BW'(1);
          if (valid)
            pending_reg <= 1'b1;
          if (last_shift) begin
            HEX_1 <= seg(bcd_step[7:4]);
            HEX_0 <= seg(bcd_step[3:0]);
            HEX_2 <= sel_rem ? SEG_R : (conv_neg_reg ? SEG_MINUS : SEG_BLANK);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid || pending_reg || timeout) state_next = CONV;
      CONV:    if (last_shift) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == CONV);
  end
endmodule

// File: tb/tb_div_result_display.sv
// Bench for div_result_display: fixed vector table, corner-case sequences and random
// stimulus compared every cycle against a decimal-arithmetic reference model.
module tb_div_result_display;
  localparam int W = 6;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst, valid, neg;
  logic [5:0] cociente, residuo;
  logic       busy, sel_rem;
  logic [6:0] HEX_0, HEX_1, HEX_2;

  int checks = 0;
  int errors = 0;

  div_result_display #(.WIDTH(W), .TOGGLE_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .valid(valid), .cociente(cociente), .residuo(residuo),
    .neg(neg), .busy(busy), .sel_rem(sel_rem), .HEX_0(HEX_0), .HEX_1(HEX_1), .HEX_2(HEX_2)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         c, r;
    bit         n;
    logic [6:0] qh2, qh1, qh0, rh1, rh0;
  } vec_t;
  vec_t vecs [6];

  // Reference model state: results are held as integers and shown via /10 and %10.
  int   m_busy, m_tick, m_q, m_r, m_val;
  bit   m_pend, m_armed, m_sel, m_isrem, m_cneg, m_n;
  logic [6:0] e_h0, e_h1, e_h2;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_start(input int v, input bit is_rem, input bit ng);
    m_val = v; m_isrem = is_rem; m_cneg = ng; m_busy = W;
  endtask

  task automatic model_edge(input bit r, input bit v, input int c, input int rv, input bit ng);
    if (r) begin
      m_busy = 0; m_tick = 0; m_q = 0; m_r = 0; m_val = 0;
      m_pend = 0; m_armed = 0; m_sel = 0; m_isrem = 0; m_cneg = 0; m_n = 0;
      e_h0 = 7'h7F; e_h1 = 7'h7F; e_h2 = 7'h7F;
      return;
    end
    if (v) begin m_q = c; m_r = rv; m_n = ng; m_armed = 1; end
    if (m_busy > 0) begin
      if (v) m_pend = 1;
      m_busy--;
      if (m_busy == 0) begin
        e_h1 = seg_of(m_val / 10);
        e_h0 = seg_of(m_val % 10);
        e_h2 = m_isrem ? 7'b0101111 : (m_cneg ? 7'b0111111 : 7'b1111111);
      end
      if (m_tick < T - 1) m_tick++;
    end else if (v || m_pend) begin
      m_pend = 0; m_sel = 0; m_tick = 0;
      model_start(m_q, 0, m_n);
    end else if (m_armed && m_tick == T - 1) begin
      m_tick = 0; m_sel = !m_sel;
      model_start(m_sel ? m_r : m_q, m_sel, m_n);
    end else if (m_tick < T - 1) begin
      m_tick++;
    end
  endtask

  task automatic check_model();
    checks++;
    if (busy !== (m_busy > 0) || sel_rem !== m_sel || HEX_0 !== e_h0 ||
        HEX_1 !== e_h1 || HEX_2 !== e_h2) begin
      errors++;
      $display("FAIL model t=%0t: got busy=%b sel=%b H2=%b H1=%b H0=%b, expected busy=%b sel=%b H2=%b H1=%b H0=%b",
               $time, busy, sel_rem, HEX_2, HEX_1, HEX_0, (m_busy > 0), m_sel, e_h2, e_h1, e_h0);
    end
  endtask

  task automatic expect7(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic expect1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [5:0] c, input logic [5:0] rv, input bit ng);
    rst = r; valid = v; cociente = c; residuo = rv; neg = ng;
    @(posedge clk);
    model_edge(r, v, int'(c), int'(rv), ng);
    #1;
    rst = 1'b0; valid = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 6'd0, 6'd0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8,  0,  0, 7'b1111111, 7'b1000000, 7'b0000000, 7'b1000000, 7'b1000000};
    vecs[1] = '{7,  2,  1, 7'b0111111, 7'b1000000, 7'b1111000, 7'b1000000, 7'b0100100};
    vecs[2] = '{63, 63, 0, 7'b1111111, 7'b0000010, 7'b0110000, 7'b0000010, 7'b0110000};
    vecs[3] = '{45, 9,  1, 7'b0111111, 7'b0011001, 7'b0010010, 7'b1000000, 7'b0010000};
    vecs[4] = '{19, 10, 0, 7'b1111111, 7'b1111001, 7'b0010000, 7'b1111001, 7'b1000000};
    vecs[5] = '{36, 27, 1, 7'b0111111, 7'b0110000, 7'b0000010, 7'b0100100, 7'b1111000};

    // Reset, then a long idle stretch with no valid: display stays blank.
    step(1, 0, 6'd0, 6'd0, 1'b0);
    step(1, 0, 6'd0, 6'd0, 1'b0);
    expect7("reset_hex0", HEX_0, 7'h7F);
    expect7("reset_hex2", HEX_2, 7'h7F);
    expect1("reset_busy", busy, 1'b0);
    idle(40);
    expect1("no_toggle_sel", sel_rem, 1'b0);
    expect7("no_toggle_hex1", HEX_1, 7'h7F);

    for (int i = 0; i < 6; i++) begin
      step(0, 1, 6'(vecs[i].c), 6'(vecs[i].r), vecs[i].n);
      expect1("vec_busy_start", busy, 1'b1);
      idle(W);
      expect1("vec_busy_done", busy, 1'b0);
      expect7("vec_q_hex2", HEX_2, vecs[i].qh2);
      expect7("vec_q_hex1", HEX_1, vecs[i].qh1);
      expect7("vec_q_hex0", HEX_0, vecs[i].qh0);
      idle(T - W - 1);
      expect1("vec_sel_before", sel_rem, 1'b0);
      idle(1);
      expect1("vec_sel_toggle", sel_rem, 1'b1);
      idle(W);
      expect7("vec_r_hex2", HEX_2, 7'b0101111);
      expect7("vec_r_hex1", HEX_1, vecs[i].rh1);
      expect7("vec_r_hex0", HEX_0, vecs[i].rh0);
      idle(T);
      expect1("vec_sel_back", sel_rem, 1'b0);
      expect7("vec_back_hex0", HEX_0, vecs[i].qh0);
    end

    // Second valid while busy: first result shows, then the new one after a restart.
    step(0, 1, 6'd16, 6'd5, 1'b0);
    idle(1);
    step(0, 1, 6'd1, 6'd3, 1'b0);
    idle(W - 2);
    expect1("pend_busy_gap", busy, 1'b0);
    expect7("pend_first_hex1", HEX_1, 7'b1111001);
    expect7("pend_first_hex0", HEX_0, 7'b0000010);
    idle(1);
    expect1("pend_restart_busy", busy, 1'b1);
    expect7("pend_hold_hex0", HEX_0, 7'b0000010);
    idle(W);
    expect7("pend_second_hex1", HEX_1, 7'b1000000);
    expect7("pend_second_hex0", HEX_0, 7'b1111001);
    expect1("pend_second_sel", sel_rem, 1'b0);

    // Reset in the middle of a conversion, then a clean conversion.
    step(0, 1, 6'd25, 6'd4, 1'b1);
    idle(3);
    step(1, 1, 6'd12, 6'd2, 1'b0);
    expect1("midrst_busy", busy, 1'b0);
    expect7("midrst_hex0", HEX_0, 7'h7F);
    expect7("midrst_hex1", HEX_1, 7'h7F);
    expect7("midrst_hex2", HEX_2, 7'h7F);
    idle(2);
    step(0, 1, 6'd42, 6'd11, 1'b1);
    idle(W);
    expect7("after_rst_hex2", HEX_2, 7'b0111111);
    expect7("after_rst_hex1", HEX_1, 7'b0011001);
    expect7("after_rst_hex0", HEX_0, 7'b0100100);

    // Random traffic, including valids during conversion and rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
           6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
